key_expand_ctrl: RTL and testbench

//  Sequences AES-128 key expansion: accepts a cipher key, iterates round_key_tf for rounds 1..10,

---
 rtl/aes_pkg.sv | 63 ++++++
 rtl/key_expand_ctrl_if.sv | 26 ++
 rtl/round_key_tf.sv | 75 +++++++
 rtl/key_expand_ctrl.sv | 152 +++++++++++++++
 tb/tb_key_expand_ctrl.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/aes_pkg.sv
// Shared AES definitions: widths, round-key type, key-expansion FSM states and GF(2^8) helpers.
package aes_pkg;

    localparam int unsigned KEY_W      = 128;
    localparam int unsigned WORD_W     = 32;
    localparam int unsigned NUM_ROUNDS = 10;

    typedef logic [KEY_W-1:0] round_key_t;

    typedef enum logic [2:0] {
        KE_IDLE,
        KE_START,
        KE_WAIT,
        KE_STORE,
        KE_DONE
    } key_exp_state_e;

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        logic [7:0] y;
        p = 8'h00;
        x = a;
        y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
            y = y >> 1;
        end
        return p;
    endfunction

    // S-box as multiplicative inverse (a^254) followed by the affine transform.
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] inv;
        sq  = a;
        inv = 8'h01;
        for (int i = 0; i < 7; i++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                   ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] idx);
        case (idx)
            4'd0:    return 8'h01;
            4'd1:    return 8'h02;
            4'd2:    return 8'h04;
            4'd3:    return 8'h08;
            4'd4:    return 8'h10;
            4'd5:    return 8'h20;
            4'd6:    return 8'h40;
            4'd7:    return 8'h80;
            4'd8:    return 8'h1b;
            4'd9:    return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

endpackage

// File: rtl/key_expand_ctrl_if.sv
// Key-load handshake and round-key read port between the key source/cipher and key_expand_ctrl.
interface key_expand_ctrl_if;
    import aes_pkg::*;

    logic       key_valid_i;
    logic       key_ready_o;
    round_key_t key_i;
    logic       busy_o;
    logic       keys_done_o;
    logic       rd_en_i;
    logic [3:0] rd_idx_i;
    round_key_t rd_key_o;
    logic       rd_valid_o;
    logic       rd_err_o;

    modport master (
        output key_valid_i, key_i, rd_en_i, rd_idx_i,
        input  key_ready_o, busy_o, keys_done_o, rd_key_o, rd_valid_o, rd_err_o
    );

    modport slave (
        input  key_valid_i, key_i, rd_en_i, rd_idx_i,
        output key_ready_o, busy_o, keys_done_o, rd_key_o, rd_valid_o, rd_err_o
    );

endinterface

// File: rtl/round_key_tf.sv
// One AES-128 key-schedule step. SubWord runs SBOX_PAR bytes per cycle, so latency from
// start_i to the done_o pulse is 4/SBOX_PAR + 1 cycles; key_o stays valid until the next start.
module round_key_tf
    import aes_pkg::*;
#(
    parameter int unsigned SBOX_PAR = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start_i,
    input  round_key_t key_i,
    input  logic [3:0] round_count_i,
    output round_key_t key_o,
    output logic       done_o
);

    localparam int unsigned NumGrp = 4 / SBOX_PAR;

    round_key_t  key_q;
    logic [7:0]  rcon_q;
    logic [31:0] sub_q, sub_d;
    logic [1:0]  grp_q;
    logic        run_q;
    logic        done_q;
    logic [31:0] rot;

    assign rot = {key_q[23:0], key_q[31:24]};

    always_comb begin
        int unsigned lane;
        lane  = 0;
        sub_d = sub_q;
        for (int j = 0; j < int'(SBOX_PAR); j++) begin
            lane = int'(grp_q) * SBOX_PAR + j;
            sub_d[8*lane +: 8] = sbox(rot[8*lane +: 8]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_q  <= '0;
            rcon_q <= '0;
            sub_q  <= '0;
            grp_q  <= '0;
            run_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (start_i) begin
                key_q  <= key_i;
                rcon_q <= rcon(round_count_i);
                grp_q  <= '0;
                run_q  <= 1'b1;
            end else if (run_q) begin
                sub_q <= sub_d;
                if (grp_q == 2'(NumGrp - 1)) begin
                    run_q  <= 1'b0;
                    done_q <= 1'b1;
                end else begin
                    grp_q <= grp_q + 2'd1;
                end
            end
        end
    end

    logic [31:0] tmp, w0, w1, w2, w3;
    assign tmp    = sub_q ^ {rcon_q, 24'h000000};
    assign w0     = key_q[127:96] ^ tmp;
    assign w1     = key_q[95:64] ^ w0;
    assign w2     = key_q[63:32] ^ w1;
    assign w3     = key_q[31:0] ^ w2;
    assign key_o  = {w0, w1, w2, w3};
    assign done_o = done_q;

endmodule

// File: rtl/key_expand_ctrl.sv
// AES-128 key-expansion sequencer with an 11-entry round-key store and indexed read port.
// Optional KEY_EXP_ZEROIZE_EN adds zeroize_i to wipe the store and abort expansion.
module key_expand_ctrl
    import aes_pkg::*;
#(
    parameter int unsigned SBOX_PAR   = 4,
    parameter int unsigned NUM_ROUNDS = 10
) (
    input logic clk,
    input logic rst,
`ifdef KEY_EXP_ZEROIZE_EN
    input logic zeroize_i,
`endif
    key_expand_ctrl_if.slave bus
);

    key_exp_state_e state_q, state_d;
    logic [3:0]     round_q, count_q;
    round_key_t     rk_q [0:10];

    logic       zeroize;
    logic       idle_like;
    logic       accept;
    logic       rst_n;
    logic       tf_start;
    logic       tf_done;
    round_key_t tf_key_in;
    round_key_t tf_key_out;
    logic [3:0] prev_idx;

`ifdef KEY_EXP_ZEROIZE_EN
    assign zeroize = zeroize_i;
`else
    assign zeroize = 1'b0;
`endif

    assign rst_n     = ~rst;
    assign idle_like = (state_q == KE_IDLE) || (state_q == KE_DONE);
    assign accept    = idle_like && bus.key_valid_i && !zeroize;
    assign prev_idx  = round_q - 4'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= KE_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (zeroize) begin
            state_d = KE_IDLE;
        end else begin
            unique case (state_q)
                KE_IDLE, KE_DONE: if (bus.key_valid_i) state_d = KE_START;
                KE_START:         state_d = KE_WAIT;
                // done_o is only looked at here, never in START
                KE_WAIT:          if (tf_done) state_d = KE_STORE;
                KE_STORE:         state_d = (round_q == 4'(NUM_ROUNDS)) ? KE_DONE : KE_START;
                default:          state_d = KE_IDLE;
            endcase
        end
    end

    always_comb begin
        bus.busy_o      = (state_q == KE_START) || (state_q == KE_WAIT) || (state_q == KE_STORE);
        bus.keys_done_o = (state_q == KE_DONE);
        bus.key_ready_o = idle_like && !rst;
        tf_start        = (state_q == KE_START);
    end

    always_comb begin
        tf_key_in = '0;
        for (int i = 0; i < 11; i++) begin
            if (prev_idx == 4'(i)) tf_key_in = rk_q[i];
        end
    end

    round_key_tf #(
        .SBOX_PAR(SBOX_PAR)
    ) u_rk_tf (
        .clk          (clk),
        .rst_n        (rst_n),
        .start_i      (tf_start),
        .key_i        (tf_key_in),
        .round_count_i(prev_idx),
        .key_o        (tf_key_out),
        .done_o       (tf_done)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            round_q <= '0;
            count_q <= '0;
            for (int i = 0; i < 11; i++) rk_q[i] <= '0;
        end else if (zeroize) begin
            round_q <= '0;
            count_q <= '0;
            for (int i = 0; i < 11; i++) rk_q[i] <= '0;
        end else if (accept) begin
            rk_q[0] <= bus.key_i;
            count_q <= 4'd1;
            round_q <= 4'd1;
        end else if (state_q == KE_STORE) begin
            for (int i = 1; i < 11; i++) begin
                if (round_q == 4'(i)) rk_q[i] <= tf_key_out;
            end
            count_q <= count_q + 4'd1;
            round_q <= round_q + 4'd1;
        end
    end

    // Read port; a read of the entry being stored this cycle bypasses to the transform output.
    logic       bypass;
    logic       hit;
    round_key_t rd_word;
    round_key_t rd_key_q;
    logic       rd_valid_q, rd_err_q;

    assign bypass = (state_q == KE_STORE) && (bus.rd_idx_i == round_q);
    assign hit    = (bus.rd_idx_i <= 4'd10) && ((bus.rd_idx_i < count_q) || bypass);

    always_comb begin
        rd_word = '0;
        for (int i = 0; i < 11; i++) begin
            if (bus.rd_idx_i == 4'(i)) rd_word = rk_q[i];
        end
        if (bypass) rd_word = tf_key_out;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_key_q   <= '0;
            rd_valid_q <= 1'b0;
            rd_err_q   <= 1'b0;
        end else begin
            rd_valid_q <= 1'b0;
            rd_err_q   <= 1'b0;
            if (bus.rd_en_i) begin
                if (!zeroize && hit) begin
                    rd_valid_q <= 1'b1;
                    rd_key_q   <= rd_word;
                end else begin
                    rd_err_q <= 1'b1;
                end
            end
        end
    end

    assign bus.rd_key_o   = rd_key_q;
    assign bus.rd_valid_o = rd_valid_q;
    assign bus.rd_err_o   = rd_err_q;

endmodule

// File: tb/tb_key_expand_ctrl.sv
// Directed bench for key_expand_ctrl: FIPS-197 vectors, early reads, range errors, re-accept,
// asynchronous reset and (with KEY_EXP_ZEROIZE_EN) zeroize.
module tb_key_expand_ctrl;
    import aes_pkg::*;

    localparam int unsigned LTF      = 2;  // round_key_tf latency with SBOX_PAR=4
    localparam int          EXP_DONE = 10 * (LTF + 2) + 1;

    localparam logic [127:0] KEY_A    = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] KEY_A_R1 = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] KEY_A_RA = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] KEY_B    = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] KEY_B_R1 = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;
    localparam logic [127:0] KEY_B_RA = 128'h13111d7fe3944a17f307a78b4d2b30c5;

    logic clk = 1'b0;
    logic rst = 1'b1;
`ifdef KEY_EXP_ZEROIZE_EN
    logic zeroize = 1'b0;
`endif

    int checks = 0;
    int errors = 0;

    key_expand_ctrl_if bus ();

    key_expand_ctrl #(
        .SBOX_PAR  (4),
        .NUM_ROUNDS(10)
    ) dut (
        .clk      (clk),
        .rst      (rst),
`ifdef KEY_EXP_ZEROIZE_EN
        .zeroize_i(zeroize),
`endif
        .bus      (bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Key must already be offered; returns edges to keys_done_o (accept edge = 1).
    task automatic run_expand(output int n_done, output int n_valid, output logic [127:0] k_valid);
        n_done  = 0;
        n_valid = 0;
        k_valid = '0;
        for (int n = 1; n <= 100; n++) begin
            step();
            if (n == 1) begin
                bus.key_valid_i = 1'b0;
                check("busy_after_accept", 128'(bus.busy_o), 128'(1));
            end
            if (bus.rd_en_i && n == 1) check("early_err_first", 128'(bus.rd_err_o), 128'(1));
            if (bus.rd_valid_o && n_valid == 0) begin
                n_valid = n;
                k_valid = bus.rd_key_o;
            end
            if (bus.keys_done_o) begin
                n_done = n;
                break;
            end
        end
    endtask

    initial begin
        int            n_done, n_valid;
        logic [127:0]  k_valid;
        logic [127:0]  held;

        bus.key_valid_i = 1'b0;
        bus.key_i       = '0;
        bus.rd_en_i     = 1'b0;
        bus.rd_idx_i    = '0;

        // Reset state
        step();
        step();
        check("rst_key_ready", 128'(bus.key_ready_o), 128'(0));
        check("rst_busy", 128'(bus.busy_o), 128'(0));
        check("rst_done", 128'(bus.keys_done_o), 128'(0));
        check("rst_rd_valid", 128'(bus.rd_valid_o), 128'(0));
        check("rst_rd_key", bus.rd_key_o, 128'h0);
        rst = 1'b0;
        #1;
        check("idle_key_ready", 128'(bus.key_ready_o), 128'(1));

        // FIPS-197 expansion with idx 1 polled from accept
        bus.key_i       = KEY_A;
        bus.key_valid_i = 1'b1;
        bus.rd_en_i     = 1'b1;
        bus.rd_idx_i    = 4'd1;
        run_expand(n_done, n_valid, k_valid);
        check("latency_a", 128'(n_done), 128'(EXP_DONE));
        check("early_valid_edge", 128'(n_valid), 128'(LTF + 3));
        check("early_valid_key", k_valid, KEY_A_R1);
        check("done_busy", 128'(bus.busy_o), 128'(0));
        check("done_ready", 128'(bus.key_ready_o), 128'(1));

        bus.rd_idx_i = 4'd0;
        step();
        check("rd0_valid", 128'(bus.rd_valid_o), 128'(1));
        check("rd0_key", bus.rd_key_o, KEY_A);
        bus.rd_idx_i = 4'd10;
        step();
        check("rd10_key", bus.rd_key_o, KEY_A_RA);
        held = KEY_A_RA;
        bus.rd_idx_i = 4'd11;
        step();
        check("rd11_err", 128'(bus.rd_err_o), 128'(1));
        check("rd11_valid", 128'(bus.rd_valid_o), 128'(0));
        check("rd11_hold", bus.rd_key_o, held);
        bus.rd_idx_i = 4'd15;
        step();
        check("rd15_err", 128'(bus.rd_err_o), 128'(1));
        check("rd15_hold", bus.rd_key_o, held);
        bus.rd_en_i = 1'b0;
        step();
        check("idle_rd_valid", 128'(bus.rd_valid_o), 128'(0));
        check("idle_rd_err", 128'(bus.rd_err_o), 128'(0));

        // Back-to-back second key offered in DONE
        bus.key_i       = KEY_B;
        bus.key_valid_i = 1'b1;
        run_expand(n_done, n_valid, k_valid);
        check("latency_b", 128'(n_done), 128'(EXP_DONE));
        bus.rd_en_i  = 1'b1;
        bus.rd_idx_i = 4'd1;
        step();
        check("b_rd1_key", bus.rd_key_o, KEY_B_R1);
        bus.rd_idx_i = 4'd10;
        step();
        check("b_rd10_key", bus.rd_key_o, KEY_B_RA);

        // Asynchronous reset in the round-5 WAIT
        bus.key_i       = KEY_A;
        bus.key_valid_i = 1'b1;
        bus.rd_idx_i    = 4'd0;
        step();
        bus.key_valid_i = 1'b0;
        check("b2b_done_drops", 128'(bus.keys_done_o), 128'(0));
        repeat (17) step();
        check("mid_busy", 128'(bus.busy_o), 128'(1));
        check("mid_rd_valid", 128'(bus.rd_valid_o), 128'(1));
        #2 rst = 1'b1;
        #1;
        check("arst_busy", 128'(bus.busy_o), 128'(0));
        check("arst_ready", 128'(bus.key_ready_o), 128'(0));
        check("arst_rd_valid", 128'(bus.rd_valid_o), 128'(0));
        check("arst_rd_key", bus.rd_key_o, 128'h0);
        bus.rd_en_i = 1'b0;
        #3 rst = 1'b0;
        #1;
        check("post_rst_ready", 128'(bus.key_ready_o), 128'(1));
        bus.rd_en_i  = 1'b1;
        bus.rd_idx_i = 4'd0;
        step();
        check("post_rst_rd_err", 128'(bus.rd_err_o), 128'(1));
        check("post_rst_rd_valid", 128'(bus.rd_valid_o), 128'(0));
        bus.rd_en_i = 1'b0;

`ifdef KEY_EXP_ZEROIZE_EN
        // Zeroize during round 3 beats a simultaneous key offer and read
        bus.key_i       = KEY_A;
        bus.key_valid_i = 1'b1;
        step();
        bus.key_valid_i = 1'b0;
        repeat (9) step();
        check("z_busy_before", 128'(bus.busy_o), 128'(1));
        zeroize         = 1'b1;
        bus.key_i       = KEY_B;
        bus.key_valid_i = 1'b1;
        bus.rd_en_i     = 1'b1;
        bus.rd_idx_i    = 4'd0;
        step();
        zeroize         = 1'b0;
        bus.key_valid_i = 1'b0;
        check("z_rd_err", 128'(bus.rd_err_o), 128'(1));
        check("z_busy", 128'(bus.busy_o), 128'(0));
        check("z_ready", 128'(bus.key_ready_o), 128'(1));
        check("z_done", 128'(bus.keys_done_o), 128'(0));
        step();
        check("z_rd0_err", 128'(bus.rd_err_o), 128'(1));
        bus.rd_en_i = 1'b0;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
